layer_ctrl: RTL and testbench
=============================

# layer_ctrl

Sequencer for one `layer` instance (conv → activation → pooling). On a `start` pulse it:
- latches the kernel and bias;
- flushes the layer;
- streams the W×W input image from an external input buffer into the layer at one pixel per cycle;
- writes every pooled result to an output buffer at consecutive addresses, then reports completion.

It sits between the on-chip feature-map buffers and the layer datapath, and replaces the testbench-style feeding loop with synthesizable control.

## Interface
Parameters:
- dataWidth, 8, pixel/weight/bias width
- W, 30, input image side
- K, 3, kernel side
- P, 2, pooling window side
- NOUT, ((W-K+1)/P)*((W-K+1)/P) (=196), pooled outputs per run
- IN_AW, $clog2(W*W) (=10), input address width
- OUT_AW, $clog2(NOUT) (=8), output address width
- TIMEOUT, 64, drain watchdog limit in cycles (used only with the macro)

Ports:
- clk  in  1  clock, all logic on rising edge
- global_rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE only
- weight_in  in  K*K*dataWidth  kernel, tap i at bits [i*dataWidth +: dataWidth]
- bias_in  in  dataWidth  bias
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle completion pulse
- in_rd_en  out  1  input-buffer read strobe; data returns next cycle
- in_addr  out  IN_AW  input-buffer read address, raster order
- in_data  in  dataWidth  input-buffer read data
- layer_rst  out  1  active-high synchronous reset to the layer
- layer_ce  out  1  layer clock enable
- layer_input  out  dataWidth  pixel to the layer (= in_data while streaming, 0 in DRAIN)
- layer_weight  out  K*K*dataWidth  latched kernel
- layer_bias  out  dataWidth  latched bias
- layer_valid  in  1  layer pooled-output valid
- layer_data  in  dataWidth  layer pooled output
- out_wr_en  out  1  output-buffer write strobe
- out_addr  out  OUT_AW  output-buffer write address
- out_data  out  dataWidth  output-buffer write data
- err  out  1  sticky drain timeout flag, cleared on next accepted start

## Operation
FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.

- **IDLE**
  - layer_rst=1, layer_ce=0.
  - On start=1: latch weight_in/bias_in into layer_weight/layer_bias, clear the counters, clear err, then go to LOAD.
- **LOAD**
  - Lasts exactly 2 cycles, layer_rst=1.
  - Then go to STREAM.
- **STREAM**
  - layer_rst=0.
  - in_rd_en=1 with in_addr=0,1,…,W*W-1, one per cycle.
  - layer_ce equals in_rd_en delayed one cycle, so each pixel enters the layer aligned with its in_data.
  - After the read at address W*W-1, go to DRAIN.
- **DRAIN**
  - in_rd_en=0, layer_ce=1, layer_input=0.
  - When the output count reaches NOUT, go to DONE.
- **DONE**
  - done=1 for one cycle, busy=0, then go to IDLE.
- **Output capture** (STREAM and DRAIN):
  - Each cycle with layer_valid=1 and count<NOUT, register out_wr_en=1, out_addr=count, out_data=layer_data; then count++.
  - layer_valid with count≥NOUT is ignored.
  - Reaching NOUT during STREAM does not shorten the stream; the exit to DONE is taken from DRAIN.
- **Start handling:** start while busy is ignored. start held high through DONE→IDLE is accepted again in IDLE.
- **Counter widths:** the input address counter is IN_AW bits and stops at W*W-1, with no wrap. The output counter is OUT_AW+1 bits so that it can hold NOUT.

## Timing
- **Reset:** global_rst_n low forces IDLE asynchronously, including mid-run. Reset values:
  - busy=0, done=0, in_rd_en=0, in_addr=0
  - layer_rst=1, layer_ce=0, layer_input=0, layer_weight=0, layer_bias=0
  - out_wr_en=0, out_addr=0, out_data=0, err=0
- **Cycle numbering:** start is sampled at edge 0.
  - Edge 1: busy=1; cycles 1–2 are LOAD.
  - First in_rd_en in cycle 3; first layer_ce in cycle 4.
  - Last in_rd_en in cycle 3+W*W-1; last STREAM-fed layer_ce one cycle later.
- **Output write:** out_wr_en trails the accepted layer_valid by 1 cycle.
- **Completion:** done is asserted the cycle after the NOUT-th out_wr_en. busy falls in the same cycle that done rises.

## Configuration
- **LAYER_CTRL_TIMEOUT_EN defined:** in DRAIN, a counter measures cycles since the last accepted layer_valid (or since DRAIN entry).
  - On reaching TIMEOUT: set err=1, go to DONE (done pulses normally) and discard the missing outputs.
  - The counter resets on every accepted layer_valid.
- **Undefined:** no watchdog; DRAIN waits indefinitely. err is tied to 0 (the port is kept).

## Test plan
- **Nominal run:** W=30, K=3, P=2, all-ones image, kernel all 1, bias 0, ReLU model.
  - Expect exactly 196 writes to addresses 0..195, each value 9.
  - done is a single pulse; err=0.
- **Read alignment:** in_data = address[7:0].
  - layer_input in cycle n+1 equals the address issued in cycle n.
  - 900 layer_ce cycles during feeding; first in_rd_en exactly 3 cycles after the start edge.
- **Start while busy:** pulse start at cycles 10 and 500.
  - Only one run occurs: one done pulse, 196 writes; layer_weight is unchanged by the second pulse.
- **Async reset mid-STREAM:** drop global_rst_n at in_addr=400.
  - All outputs take their reset values immediately, with layer_rst=1.
  - A fresh start afterwards completes with 196 writes.
- **Excess valids:** the layer model emits 200 valids.
  - Only 196 writes occur; out_addr never exceeds 195.
- **Timeout** (macro defined, TIMEOUT=64): the layer model stops at 150 valids.
  - err=1 and done pulse 64 cycles after the 150th valid (or after DRAIN entry, if later).
  - err clears on the next start.

Source files
------------

// File: rtl/layer_ctrl.sv
// layer_ctrl: sequencer for one conv -> activation -> pooling layer instance.
//
// On an accepted start it latches the kernel and bias, holds the layer in reset
// for two cycles, streams the W x W input image from the input buffer at one
// pixel per cycle, then drains the layer until NOUT pooled results have been
// written to the output buffer, and finally pulses done.
//
// Optional feature: define LAYER_CTRL_TIMEOUT_EN to enable a drain watchdog. It
// sets the sticky err flag and forces completion after TIMEOUT idle DRAIN cycles.
//
// Ports:
//   clk, global_rst_n        clock, asynchronous active-low reset
//   start                    run request (sampled in IDLE only)
//   weight_in, bias_in       kernel/bias, latched on accepted start
//   busy, done, err          status: running, one-cycle completion, drain timeout
//   in_rd_en, in_addr        input-buffer read port (data returns next cycle)
//   in_data                  input-buffer read data
//   layer_rst, layer_ce      synchronous reset and clock enable to the layer
//   layer_input              pixel to the layer
//   layer_weight, layer_bias latched kernel and bias
//   layer_valid, layer_data  pooled output from the layer
//   out_wr_en, out_addr,     output-buffer write port
//   out_data
module layer_ctrl #(
  parameter int unsigned dataWidth = 8,
  parameter int unsigned W         = 30,
  parameter int unsigned K         = 3,
  parameter int unsigned P         = 2,
  parameter int unsigned NOUT      = ((W - K + 1) / P) * ((W - K + 1) / P),
  parameter int unsigned IN_AW     = $clog2(W * W),
  parameter int unsigned OUT_AW    = $clog2(NOUT),
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       global_rst_n,
  input  logic                       start,
  input  logic [K*K*dataWidth-1:0]   weight_in,
  input  logic [dataWidth-1:0]       bias_in,
  output logic                       busy,
  output logic                       done,
  output logic                       in_rd_en,
  output logic [IN_AW-1:0]           in_addr,
  input  logic [dataWidth-1:0]       in_data,
  output logic                       layer_rst,
  output logic                       layer_ce,
  output logic [dataWidth-1:0]       layer_input,
  output logic [K*K*dataWidth-1:0]   layer_weight,
  output logic [dataWidth-1:0]       layer_bias,
  input  logic                       layer_valid,
  input  logic [dataWidth-1:0]       layer_data,
  output logic                       out_wr_en,
  output logic [OUT_AW-1:0]          out_addr,
  output logic [dataWidth-1:0]       out_data,
  output logic                       err
);

  typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StDone} state_e;

  // One spare bit so the output counter can hold NOUT itself.
  localparam int unsigned         CntW     = OUT_AW + 1;
  localparam logic [IN_AW-1:0]    LastAddr = IN_AW'(W * W - 1);
  localparam logic [CntW-1:0]     NoutCnt  = CntW'(NOUT);

  state_e             state_q, state_d;
  logic               start_q;     // start was accepted at the previous edge
  logic               load_cnt_q;  // second LOAD cycle
  logic               rd_q;        // read issued last cycle: in_data is valid now
  logic [IN_AW-1:0]   addr_q;
  logic [CntW-1:0]    out_cnt_q;
  logic               accept_start;
  logic               capture;
  logic               timeout_hit;

  // start_q gates re-acceptance so a held start is taken only once per IDLE visit.
  assign accept_start = (state_q == StIdle) && start && !start_q;
  assign capture      = layer_valid && (out_cnt_q < NoutCnt) &&
                        ((state_q == StStream) || (state_q == StDrain));

`ifdef LAYER_CTRL_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           err_q;

  // Counts DRAIN cycles without an accepted valid; zero outside DRAIN.
  assign timeout_hit = (state_q == StDrain) && !capture && (to_cnt_q == ToW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q != StDrain) || capture) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end
      if (accept_start) begin
        err_q <= 1'b0;
      end else if (timeout_hit && (out_cnt_q != NoutCnt)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_q) state_d = StLoad;
      StLoad:   if (load_cnt_q) state_d = StStream;
      StStream: if (addr_q == LastAddr) state_d = StDrain;
      StDrain:  if ((out_cnt_q == NoutCnt) || timeout_hit) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    busy        = (state_q == StLoad) || (state_q == StStream) || (state_q == StDrain);
    done        = (state_q == StDone);
    in_rd_en    = (state_q == StStream);
    layer_rst   = (state_q == StIdle) || (state_q == StLoad);
    // The last streamed pixel arrives in the first DRAIN cycle, so feed in_data
    // whenever a read was issued last cycle and zeros otherwise.
    layer_ce    = rd_q || (state_q == StDrain);
    layer_input = rd_q ? in_data : '0;
  end

  assign in_addr = addr_q;

  // Counters, latched configuration and registered output-buffer write port.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      start_q      <= 1'b0;
      load_cnt_q   <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      out_cnt_q    <= '0;
      layer_weight <= '0;
      layer_bias   <= '0;
      out_wr_en    <= 1'b0;
      out_addr     <= '0;
      out_data     <= '0;
    end else begin
      start_q    <= accept_start;
      load_cnt_q <= (state_q == StLoad) && !load_cnt_q;
      rd_q       <= in_rd_en;
      if (accept_start) begin
        layer_weight <= weight_in;
        layer_bias   <= bias_in;
        addr_q       <= '0;
        out_cnt_q    <= '0;
      end else begin
        // Address saturates at the last pixel; no wrap.
        if ((state_q == StStream) && (addr_q != LastAddr)) begin
          addr_q <= addr_q + IN_AW'(1);
        end
        if (capture) begin
          out_cnt_q <= out_cnt_q + CntW'(1);
        end
      end
      out_wr_en <= capture;
      if (capture) begin
        out_addr <= out_cnt_q[OUT_AW-1:0];
        out_data <= layer_data;
      end
    end
  end

endmodule

// File: tb/tb_layer_ctrl.sv
// Directed self-checking bench for layer_ctrl with a behavioural layer model
// (3x3 conv, ReLU, 2x2 max pool) and input-buffer model.
module tb_layer_ctrl;

  localparam int DW     = 8;
  localparam int W      = 30;
  localparam int K      = 3;
  localparam int P      = 2;
  localparam int NOUT   = 196;
  localparam int IN_AW  = 10;
  localparam int OUT_AW = 8;
  localparam int TO     = 64;
  localparam int WW     = K * K * DW;

  logic              clk = 1'b0;
  logic              global_rst_n = 1'b0;
  logic              start = 1'b0;
  logic [WW-1:0]     weight_in = '0;
  logic [DW-1:0]     bias_in = '0;
  logic              busy, done, in_rd_en, layer_rst, layer_ce, out_wr_en, err;
  logic [IN_AW-1:0]  in_addr;
  logic [DW-1:0]     in_data = '0;
  logic [DW-1:0]     layer_input, layer_bias, out_data;
  logic [WW-1:0]     layer_weight;
  logic              layer_valid = 1'b0;
  logic [DW-1:0]     layer_data = '0;
  logic [OUT_AW-1:0] out_addr;

  layer_ctrl #(
    .dataWidth(DW), .W(W), .K(K), .P(P), .NOUT(NOUT),
    .IN_AW(IN_AW), .OUT_AW(OUT_AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .global_rst_n(global_rst_n), .start(start),
    .weight_in(weight_in), .bias_in(bias_in),
    .busy(busy), .done(done), .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
    .layer_rst(layer_rst), .layer_ce(layer_ce), .layer_input(layer_input),
    .layer_weight(layer_weight), .layer_bias(layer_bias),
    .layer_valid(layer_valid), .layer_data(layer_data),
    .out_wr_en(out_wr_en), .out_addr(out_addr), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Free-running cycle counter.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input buffer: one-cycle read latency.
  logic [DW-1:0] img [W*W];
  always @(posedge clk) if (in_rd_en) in_data <= img[in_addr];

  // Layer model: a pooled result becomes valid one cycle after the bottom-right
  // pixel of its 4x4 receptive field is fed.
  int            pcnt = 0, vcnt = 0, xcnt = 0;
  int            vlimit = NOUT;
  int            extra = 0;
  logic [DW-1:0] pix [W*W];
  logic [DW-1:0] exp_mem [NOUT];

  function automatic int px(input int idx, input int cur_idx, input logic [DW-1:0] cur);
    return (idx == cur_idx) ? int'(cur) : int'(pix[idx]);
  endfunction

  function automatic logic [DW-1:0] pool_at(input int r, input int c, input logic [DW-1:0] cur);
    int best, s;
    best = 0;  // ReLU: negative/zero sums never win over 0
    for (int pr = r - 3; pr <= r - 2; pr++) begin
      for (int pc = c - 3; pc <= c - 2; pc++) begin
        s = int'(layer_bias);
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            s += px((pr + i) * W + pc + j, r * W + c, cur) *
                 int'(layer_weight[(i * K + j) * DW +: DW]);
          end
        end
        if (s > best) best = s;
      end
    end
    return best[DW-1:0];
  endfunction

  always @(posedge clk) begin
    layer_valid <= 1'b0;
    if (layer_rst) begin
      pcnt <= 0;
      vcnt <= 0;
      xcnt <= 0;
    end else if (layer_ce) begin
      pcnt <= pcnt + 1;
      if (pcnt < W * W) begin
        pix[pcnt] <= layer_input;
        if ((pcnt / W) >= 3 && (pcnt % W) >= 3 && (pcnt / W) % 2 == 1 &&
            (pcnt % W) % 2 == 1 && vcnt < vlimit) begin
          layer_valid   <= 1'b1;
          layer_data    <= pool_at(pcnt / W, pcnt % W, layer_input);
          exp_mem[vcnt] <= pool_at(pcnt / W, pcnt % W, layer_input);
          vcnt          <= vcnt + 1;
        end
      end else if (xcnt < extra) begin
        layer_valid <= 1'b1;
        layer_data  <= 8'hEE;
        xcnt        <= xcnt + 1;
      end
    end
  end

  // Monitor: samples on the falling edge and accumulates per-run statistics.
  logic             clr = 1'b0;
  bit               chk_align = 1'b0, chk_nom = 1'b0;
  logic             prev_rd = 1'b0;
  logic [IN_AW-1:0] prev_addr = '0;
  int wr_cnt, done_cnt, ce_feed, first_rd, first_ce, max_addr, last_wr_cyc, done_cyc;
  int addr_bad, data_bad, val_bad, align_bad, busy_bad;
  logic done_err;

  always @(negedge clk) begin
    prev_rd   <= in_rd_en;
    prev_addr <= in_addr;
    if (clr) begin
      wr_cnt <= 0; done_cnt <= 0; ce_feed <= 0; first_rd <= -1; first_ce <= -1;
      max_addr <= -1; addr_bad <= 0; data_bad <= 0; val_bad <= 0; align_bad <= 0;
      busy_bad <= 0; done_err <= 1'b0; last_wr_cyc <= 0; done_cyc <= 0;
    end else begin
      if (in_rd_en && first_rd < 0) first_rd <= cyc;
      if (layer_ce && first_ce < 0) first_ce <= cyc;
      if (layer_ce && prev_rd) begin
        ce_feed <= ce_feed + 1;
        if (chk_align && layer_input !== prev_addr[7:0]) align_bad <= align_bad + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        done_err <= err;
        if (busy !== 1'b0) busy_bad <= busy_bad + 1;
      end
      if (out_wr_en) begin
        if (int'(out_addr) != wr_cnt) addr_bad <= addr_bad + 1;
        if (wr_cnt >= NOUT || out_data !== exp_mem[wr_cnt]) data_bad <= data_bad + 1;
        if (chk_nom && out_data !== 8'd9) val_bad <= val_bad + 1;
        if (int'(out_addr) > max_addr) max_addr <= int'(out_addr);
        wr_cnt      <= wr_cnt + 1;
        last_wr_cyc <= cyc;
      end
    end
  end

  int cyc0 = 0;

  task automatic start_run(input logic [WW-1:0] w, input logic [DW-1:0] b);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    weight_in = w;
    bias_in   = b;
    start     = 1'b1;
    @(posedge clk);  // edge 0: start sampled
    #1 start = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done, 1'b1);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag);
    check({tag, "_writes"}, wr_cnt, NOUT);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_wr_addr_bad"}, addr_bad, 0);
    check({tag, "_wr_data_bad"}, data_bad, 0);
    check({tag, "_busy_at_done"}, busy_bad, 0);
    check({tag, "_err"}, done_err, 1'b0);
    check({tag, "_done_lag"}, done_cyc - last_wr_cyc, 1);
  endtask

  logic [WW-1:0] ones, alt;

  initial begin
    ones = {9{8'd1}};
    alt  = {9{8'd2}};
    for (int a = 0; a < W * W; a++) img[a] = 8'd1;

    // Reset values while reset is asserted.
    #2;
    check("rst0_ctl", {busy, done, in_rd_en, layer_rst, layer_ce, out_wr_en, err}, 7'b0001000);
    check("rst0_data", {in_addr, layer_input, layer_bias, out_addr, out_data}, '0);
    check("rst0_weight", layer_weight, '0);
    #20 global_rst_n = 1'b1;

    // Nominal run: all-ones image, unit kernel, zero bias -> every result is 9.
    chk_nom = 1'b1;
    start_run(ones, 8'd0);
    check("busy_c0", busy, 1'b0);
    @(posedge clk); #1;
    check("busy_c1", {busy, layer_rst}, 2'b11);
    wait_done(2000);
    check_run("nom");
    check("nom_val9_bad", val_bad, 0);
    check("nom_first_rd", first_rd - cyc0, 3);
    check("nom_first_ce", first_ce - cyc0, 4);
    check("nom_done_cyc", done_cyc - cyc0, 906);
    chk_nom = 1'b0;

    // Read alignment: pixel value = low address byte.
    for (int a = 0; a < W * W; a++) img[a] = a[7:0];
    chk_align = 1'b1;
    start_run(ones, 8'd3);
    wait_done(2000);
    check_run("aln");
    check("aln_ce_feed", ce_feed, W * W);
    check("aln_align_bad", align_bad, 0);
    check("aln_first_rd", first_rd - cyc0, 3);
    chk_align = 1'b0;

    // Start pulses while busy are ignored and must not relatch the kernel.
    start_run(ones, 8'd0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; weight_in = alt;
    @(posedge clk); #1 start = 1'b0;
    repeat (489) @(posedge clk);
    #1 start = 1'b1; weight_in = alt;
    @(posedge clk); #1 start = 1'b0;
    check("busy_weight_hold", layer_weight, ones);
    wait_done(2000);
    check_run("bsy");
    check("bsy_weight_after", layer_weight, ones);

    // Asynchronous reset in the middle of STREAM, then a fresh run.
    start_run(ones, 8'd1);
    begin
      int n;
      n = 0;
      while (in_addr !== 10'd400 && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("mid_addr_reached", in_addr, 10'd400);
    global_rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {busy, done, in_rd_en, layer_rst, layer_ce, out_wr_en, err}, 7'b0001000);
    check("mid_rst_data", {in_addr, layer_input, layer_bias, out_addr, out_data}, '0);
    check("mid_rst_weight", layer_weight, '0);
    @(negedge clk) global_rst_n = 1'b1;
    start_run(ones, 8'd0);
    wait_done(2000);
    check_run("rst");

    // Excess valids from the layer are dropped.
    extra = 4;
    start_run(ones, 8'd0);
    wait_done(2000);
    check_run("exc");
    check("exc_max_addr", max_addr, NOUT - 1);
    extra = 0;

`ifdef LAYER_CTRL_TIMEOUT_EN
    // Drain watchdog: layer stops after 150 results.
    vlimit = 150;
    start_run(ones, 8'd0);
    wait_done(3000);
    check("to_err", done_err, 1'b1);
    check("to_writes", wr_cnt, 150);
    check("to_done_cyc", done_cyc - cyc0, 903 + TO);
    vlimit = NOUT;
    start_run(ones, 8'd0);
    check("to_err_cleared", err, 1'b0);
    wait_done(2000);
    check_run("to2");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
